// File: rtl/ysyx_25030093_pkg.sv
// Shared types and constants for the ysyx_25030093 fetch path.
package ysyx_25030093_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StValid = 3'd3,
    StErr   = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25030093_ifu_wdt.sv
// Response watchdog for the fetch unit: counts WAIT cycles without a response.
// Instantiated by the top only when IFU_TIMEOUT_EN is defined.
module ysyx_25030093_ifu_wdt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;

  // Holds at LIMIT; the FSM leaves WAIT on expiry so wrap is never reached.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_clear) begin
      r_cnt <= 16'd0;
    end else if (i_tick && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: one outstanding imem request, valid/ready inst output to decode.
// Optional response timeout enabled by defining IFU_TIMEOUT_EN.
module ysyx_25030093_ifu
  import ysyx_25030093_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned     TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic [XLEN-1:0] next_pc,
  output logic            fetch_err
);

  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..65535");
  end

  ifu_state_e      r_state;
  ifu_state_e      w_state_d;
  logic [XLEN-1:0] r_pc;
  logic [ILEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  logic w_req_fire;
  logic w_rsp_ok;
  logic w_retire;
  logic w_timeout;

  assign w_req_fire = (r_state == StReq) && imem_req_ready;
  assign w_rsp_ok   = (r_state == StWait) && imem_rsp_valid && !imem_rsp_err;
  assign w_retire   = (r_state == StValid) && inst_ready;

`ifdef IFU_TIMEOUT_EN
  logic w_wdt_expired;

  ysyx_25030093_ifu_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdt (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clear  (w_req_fire),
    .i_tick   ((r_state == StWait) && !imem_rsp_valid),
    .o_expired(w_wdt_expired)
  );

  assign w_timeout = w_wdt_expired;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StBoot: w_state_d = StReq;
      StReq: begin
        if (imem_req_ready) w_state_d = StWait;
      end
      StWait: begin
        // A response arriving in the expiry cycle takes priority over the timeout.
        if (imem_rsp_valid) begin
          w_state_d = imem_rsp_err ? StErr : StValid;
        end else if (w_timeout) begin
          w_state_d = StErr;
        end
      end
      StValid: begin
        if (inst_ready) w_state_d = (next_pc[1:0] != 2'b00) ? StErr : StReq;
      end
      StErr:   w_state_d = StErr;
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StBoot;
      r_pc      <= RESET_PC;
      r_inst    <= INST_NOP;
      r_inst_pc <= RESET_PC;
    end else begin
      r_state <= w_state_d;
      if (w_rsp_ok) begin
        r_inst    <= imem_rsp_data;
        r_inst_pc <= r_pc;
      end
      if (w_retire) r_pc <= next_pc;
    end
  end

  assign imem_req_valid = (r_state == StReq);
  assign imem_req_addr  = r_pc;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_valid     = (r_state == StValid);
  assign fetch_err      = (r_state == StErr);

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Randomized bench for ysyx_25030093_ifu against a cycle-event reference model.
module tb_ysyx_25030093_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          TO     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] next_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  ysyx_25030093_ifu #(
    .RESET_PC   (RST_PC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .next_pc       (next_pc),
    .fetch_err     (fetch_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus knobs: percentages, reset rate in permille, response delay range.
  int          k_rdy, k_irdy, k_err, k_spur, k_mis, k_rst, k_dmin, k_dmax, k_rst_on;
  bit          k_force_en;
  logic [31:0] k_force_next;
  logic [31:0] k_data;

  // Reference model: what the fetch unit owes the outside world this cycle.
  bit          m_boot, m_pend, m_out, m_live, m_err;
  int          m_acc, m_rsp, m_err_age;
  logic [31:0] m_pc, m_inst, m_ipc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] pick_pc(input int mis);
    logic [31:0] a;
    a = RST_PC | ($urandom & 32'h0000_0FFC);
    if (pct(mis)) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic model_reset();
    m_boot    = 1'b1;
    m_pend    = 1'b0;
    m_out     = 1'b0;
    m_live    = 1'b0;
    m_err     = 1'b0;
    m_err_age = 0;
    m_pc      = RST_PC;
    m_inst    = NOP;
    m_ipc     = RST_PC;
  endtask

  task automatic set_knobs(input int rdy, input int irdy, input int err, input int spur,
                           input int mis, input int rst, input int dmin, input int dmax);
    k_rdy  = rdy;
    k_irdy = irdy;
    k_err  = err;
    k_spur = spur;
    k_mis  = mis;
    k_rst  = rst;
    k_dmin = dmin;
    k_dmax = dmax;
  endtask

  task automatic run_cycles(input int n);
    bit          do_rst;
    bit          n_boot, n_pend, n_out, n_live, n_err;
    logic [31:0] n_pc, n_inst, n_ipc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check("req_valid", 32'(imem_req_valid), 32'(m_pend));
      if (m_pend || m_boot) check("req_addr", imem_req_addr, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(m_live));
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_ipc);
      check("fetch_err", 32'(fetch_err), 32'(m_err));

      do_rst = ($urandom_range(0, 999) < k_rst) || (m_err && (m_err_age > 4)) ||
               ((k_rst_on == 1) && m_out) || ((k_rst_on == 2) && m_live);
      imem_req_ready = pct(k_rdy);
      inst_ready     = pct(k_irdy);
      next_pc        = k_force_en ? k_force_next : pick_pc(k_mis);
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      imem_rsp_data  = (k_data != 32'h0) ? k_data : $urandom;

      if (do_rst) begin
        rst_n = 1'b0;
        if (k_rst_on != 0) k_rst_on = 0;
        model_reset();
      end else begin
        rst_n  = 1'b1;
        n_boot = m_boot;
        n_pend = m_pend;
        n_out  = m_out;
        n_live = m_live;
        n_err  = m_err;
        n_pc   = m_pc;
        n_inst = m_inst;
        n_ipc  = m_ipc;
        if (m_boot) begin
          n_boot = 1'b0;
          n_pend = 1'b1;
        end
        if (m_pend && imem_req_ready) begin
          n_pend = 1'b0;
          n_out  = 1'b1;
          m_acc  = cyc;
          m_rsp  = cyc + 1 + int'($urandom_range(k_dmin, k_dmax));
        end
        if (m_out && (cyc >= m_rsp)) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_err   = pct(k_err);
          n_out          = 1'b0;
          if (imem_rsp_err) begin
            n_err = 1'b1;
          end else begin
            n_live = 1'b1;
            n_inst = imem_rsp_data;
            n_ipc  = m_pc;
          end
        end
`ifdef IFU_TIMEOUT_EN
        else if (m_out && ((cyc - m_acc) == TO)) begin
          n_out = 1'b0;
          n_err = 1'b1;
        end
`endif
        else if (!m_out && pct(k_spur)) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_err   = 1'($urandom_range(0, 1));
        end
        if (m_live && inst_ready) begin
          n_live = 1'b0;
          n_pc   = next_pc;
          if (next_pc[1:0] != 2'b00) n_err = 1'b1;
          else n_pend = 1'b1;
        end
        m_err_age = m_err ? m_err_age + 1 : 0;
        m_boot = n_boot;
        m_pend = n_pend;
        m_out  = n_out;
        m_live = n_live;
        m_err  = n_err;
        m_pc   = n_pc;
        m_inst = n_inst;
        m_ipc  = n_ipc;
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    next_pc        = 32'h0;
    k_force_en     = 1'b0;
    k_force_next   = 32'h0;
    k_data         = 32'h0;
    k_rst_on       = 0;
    m_acc          = 0;
    m_rsp          = 0;
    set_knobs(100, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    model_reset();

    // Boot with a one-cycle response, then hold the instruction unretired.
    k_data = 32'h0010_0073;
    run_cycles(9);
    k_data = 32'h0;

    // Retire to 8000_0010, then stall the request for several cycles.
    k_force_en   = 1'b1;
    k_force_next = 32'h8000_0010;
    k_irdy       = 100;
    run_cycles(1);
    k_irdy = 0;
    k_rdy  = 0;
    run_cycles(5);
    k_rdy = 100;
    run_cycles(6);

    // Misaligned next PC drives the unit into its terminal fault state.
    k_force_next = 32'h8000_0002;
    k_irdy       = 100;
    run_cycles(12);
    k_force_en = 1'b0;

    // Bus error response, spurious responses outside WAIT.
    set_knobs(100, 100, 100, 50, 0, 0, 1, 2);
    run_cycles(14);

    // Reset while waiting for a response, then while holding an instruction.
    set_knobs(100, 0, 0, 0, 0, 0, 3, 3);
    k_rst_on = 1;
    run_cycles(10);
    k_rst_on = 2;
    run_cycles(12);

    // Random traffic.
    set_knobs(60, 50, 2, 20, 3, 5, 0, 3);
    run_cycles(3000);

`ifdef IFU_TIMEOUT_EN
    // Response on the final permitted WAIT cycle, then a response that never comes.
    set_knobs(100, 100, 0, 0, 0, 0, 7, 7);
    run_cycles(30);
    set_knobs(100, 100, 0, 0, 0, 0, 40, 40);
    run_cycles(30);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
